paddle_ctrl: RTL

Upstream stage of the ball state machine: converts the four raw player push-buttons into the two 10-bit paddle centre positions (p1_position, p2_position) that the ball logic uses for hit detection and the VGA path uses for drawing. Synchronises and debounces the buttons, runs one hold/accelerate FSM per paddle on a movement tick, and clamps each paddle inside the playfield. Sits in the top level between the board buttons and the ball state machine.

---
 rtl/paddle_pkg.sv | 34 +++
 rtl/paddle_axis.sv | 134 +++++++++++++
 rtl/paddle_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/paddle_pkg.sv
// Shared paddle definitions: FSM encoding, playfield geometry defaults and
// the clamped position update used by both paddle axes.
package paddle_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_UP   = 3'b010,
    S_DOWN = 3'b100
  } paddle_state_t;

  localparam int unsigned TICK_DIV_DEF    = 500000;
  localparam int unsigned DEB_CYCLES_DEF  = 250000;
  localparam int unsigned STEP_DEF        = 4;
  localparam int unsigned ACCEL_TICKS_DEF = 16;
  localparam int unsigned POS_MIN_DEF     = 50;
  localparam int unsigned POS_MAX_DEF     = 431;
  localparam int unsigned POS_RST_DEF     = 245;
  localparam int unsigned PADDLE_HALF     = 45;

  // Widened signed arithmetic so a step past either edge clamps instead of wrapping.
  function automatic logic [9:0] move_clamped(input logic [9:0]  pos,
                                              input logic [10:0] step,
                                              input logic        dir_up,
                                              input logic [9:0]  lo,
                                              input logic [9:0]  hi);
    logic signed [11:0] t;
    if (dir_up) t = $signed({2'b00, pos}) - $signed({1'b0, step});
    else        t = $signed({2'b00, pos}) + $signed({1'b0, step});
    if (t < $signed({2'b00, lo})) return lo;
    if (t > $signed({2'b00, hi})) return hi;
    return t[9:0];
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle: button synchronisers and debouncers, hold/accelerate FSM,
// and the clamped centre position.
module paddle_axis
  import paddle_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned STEP        = STEP_DEF,
  parameter int unsigned ACCEL_TICKS = ACCEL_TICKS_DEF,
  parameter int unsigned POS_MIN     = POS_MIN_DEF,
  parameter int unsigned POS_MAX     = POS_MAX_DEF,
  parameter int unsigned POS_RST     = POS_RST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       tick,
  input  logic       freeze,
  input  logic       recentre,
  output logic [9:0] position,
  output logic       moving
);

  localparam int unsigned     DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [4:0]      ACCEL    = 5'(ACCEL_TICKS);

  logic [1:0]         raw;
  logic [1:0]         sync_a;
  logic [1:0]         sync_b;
  logic [1:0]         level;
  logic [1:0][DW-1:0] deb_cnt;
  logic               up;
  logic               dn;

  paddle_state_t      state;
  logic [4:0]         hold_cnt;
  logic [10:0]        step;

  assign raw = {btn_down, btn_up};
  assign up  = level[0];
  assign dn  = level[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      deb_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_b[i] != level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            level[i]   <= ~level[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign step = (hold_cnt < ACCEL) ? 11'(STEP) : 11'(2 * STEP);

  // Motion keys off the registered state, so a tick on the cycle the FSM
  // leaves UP/DOWN still applies one last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      position <= 10'(POS_RST);
      moving   <= 1'b0;
    end else begin
      if (freeze) begin
        state    <= S_IDLE;
        moving   <= 1'b0;
        hold_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            hold_cnt <= '0;
            if (up && !dn) begin
              state  <= S_UP;
              moving <= 1'b1;
            end else if (dn && !up) begin
              state  <= S_DOWN;
              moving <= 1'b1;
            end else begin
              moving <= 1'b0;
            end
          end
          S_UP: begin
            if (!up || dn) begin
              state    <= S_IDLE;
              moving   <= 1'b0;
              hold_cnt <= '0;
            end else if (tick && hold_cnt < ACCEL) begin
              hold_cnt <= hold_cnt + 5'd1;
            end
          end
          S_DOWN: begin
            if (!dn || up) begin
              state    <= S_IDLE;
              moving   <= 1'b0;
              hold_cnt <= '0;
            end else if (tick && hold_cnt < ACCEL) begin
              hold_cnt <= hold_cnt + 5'd1;
            end
          end
          default: begin
            state    <= S_IDLE;
            moving   <= 1'b0;
            hold_cnt <= '0;
          end
        endcase
      end

      if (recentre) begin
        position <= 10'(POS_RST);
        hold_cnt <= '0;
      end else if (!freeze && tick && state == S_UP) begin
        position <= move_clamped(position, step, 1'b1, 10'(POS_MIN), 10'(POS_MAX));
      end else if (!freeze && tick && state == S_DOWN) begin
        position <= move_clamped(position, step, 1'b0, 10'(POS_MIN), 10'(POS_MAX));
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Converts the four raw player buttons into the two paddle centre positions;
// owns the reset synchroniser, the shared movement tick and both paddle axes.
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned STEP        = STEP_DEF,
  parameter int unsigned ACCEL_TICKS = ACCEL_TICKS_DEF,
  parameter int unsigned POS_MIN     = POS_MIN_DEF,
  parameter int unsigned POS_MAX     = POS_MAX_DEF,
  parameter int unsigned POS_RST     = POS_RST_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       freeze,
  input  logic       recentre,
  output logic [9:0] p1_position,
  output logic [9:0] p2_position,
  output logic       p1_moving,
  output logic       p2_moving
);

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [1:0]    rst_pipe;
  logic          rst_int;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  // Reset asserts immediately and releases two clocks later, in step with clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe <= '1;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];
  assign tick    = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  paddle_axis #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STEP        (STEP),
    .ACCEL_TICKS (ACCEL_TICKS),
    .POS_MIN     (POS_MIN),
    .POS_MAX     (POS_MAX),
    .POS_RST     (POS_RST)
  ) u_p1 (
    .clk      (clk),
    .reset    (rst_int),
    .btn_up   (p1_up),
    .btn_down (p1_down),
    .tick     (tick),
    .freeze   (freeze),
    .recentre (recentre),
    .position (p1_position),
    .moving   (p1_moving)
  );

  paddle_axis #(
    .DEB_CYCLES  (DEB_CYCLES),
    .STEP        (STEP),
    .ACCEL_TICKS (ACCEL_TICKS),
    .POS_MIN     (POS_MIN),
    .POS_MAX     (POS_MAX),
    .POS_RST     (POS_RST)
  ) u_p2 (
    .clk      (clk),
    .reset    (rst_int),
    .btn_up   (p2_up),
    .btn_down (p2_down),
    .tick     (tick),
    .freeze   (freeze),
    .recentre (recentre),
    .position (p2_position),
    .moving   (p2_moving)
  );

endmodule
